// File: rtl/de0_nano_system_multitimer.sv
`default_nettype none
// ============================================================================
// Module   : de0_nano_system_multitimer
// Brief    : Avalon-MM multi-channel down-counting timer. Each channel has its
//            own STATUS/CONTROL/PERIOD/SNAP registers, an 8-bit prescaler and
//            an interrupt output.
// Revision : 1.0 - initial release
// ============================================================================
module de0_nano_system_multitimer #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 9999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [3:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [1:0]       c_REG_STATUS  = 2'd0;
    localparam logic [1:0]       c_REG_CONTROL = 2'd1;
    localparam logic [1:0]       c_REG_PERIOD  = 2'd2;
    localparam logic [1:0]       c_REG_SNAP    = 2'd3;
    localparam logic [CNT_W-1:0] c_RESET_CNT   = CNT_W'(RESET_PERIOD);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
    logic [NUM_CH-1:0][CNT_W-1:0] snap_q, snap_d;
    logic [NUM_CH-1:0][7:0]       presc_q, presc_d;
    logic [NUM_CH-1:0][7:0]       pcnt_q, pcnt_d;
    logic [NUM_CH-1:0]            to_q, to_d;
    logic [NUM_CH-1:0]            run_q, run_d;
    logic [NUM_CH-1:0]            ito_q, ito_d;
    logic [NUM_CH-1:0]            cont_q, cont_d;
    logic [31:0]                  readdata_q, readdata_d;

    logic                         w_wr;
    logic [NUM_CH-1:0]            w_sel;
    logic [NUM_CH-1:0]            w_tick;
    logic [NUM_CH-1:0]            w_tmo;

    assign w_wr     = chipselect && !write_n;
    assign readdata = readdata_q;
    assign irq      = |irq_vec;

    // Per-channel decode: write select, prescaler tick and timeout event.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_sel[g]   = w_wr && (address[3:2] == 2'(g));
        assign w_tick[g]  = run_q[g] && (pcnt_q[g] == presc_q[g]);
        assign w_tmo[g]   = w_tick[g] && (cnt_q[g] == '0);
        assign irq_vec[g] = to_q[g] & ito_q[g];
    end

    // Next-state for every channel: counting first, then bus writes override.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        snap_d   = snap_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        to_d     = to_q;
        run_d    = run_q;
        ito_d    = ito_q;
        cont_d   = cont_q;
        for (int n = 0; n < NUM_CH; n++) begin
            // Prescaler free-runs only while RUN; wraps to 0 on each tick.
            pcnt_d[n] = (run_q[n] && !w_tick[n]) ? pcnt_q[n] + 8'd1 : 8'd0;
            if (w_tick[n]) begin
                cnt_d[n] = w_tmo[n] ? period_q[n] : cnt_q[n] - 1'b1;
            end
            if (w_tmo[n]) begin
                to_d[n] = 1'b1;
                if (!cont_q[n]) begin
                    run_d[n] = 1'b0;
                end
            end
            if (w_sel[n]) begin
                case (address[1:0])
                    // Clearing TO must not swallow a timeout landing this cycle.
                    c_REG_STATUS: to_d[n] = w_tmo[n];
                    c_REG_CONTROL: begin
                        ito_d[n]   = writedata[0];
                        cont_d[n]  = writedata[1];
                        presc_d[n] = writedata[15:8];
                        if (writedata[2]) begin
                            run_d[n]  = 1'b1;
                            pcnt_d[n] = 8'd0;
                        end else if (writedata[3]) begin
                            run_d[n]  = 1'b0;
                            pcnt_d[n] = 8'd0;
                        end
                    end
                    c_REG_PERIOD: begin
                        period_d[n] = writedata[CNT_W-1:0];
                        cnt_d[n]    = writedata[CNT_W-1:0];
                        run_d[n]    = 1'b0;
                        pcnt_d[n]   = 8'd0;
                    end
                    default: snap_d[n] = cnt_q[n];
                endcase
            end
        end
    end

    // Read mux; channels beyond NUM_CH read as zero.
    always_comb begin
        readdata_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (address[3:2] == 2'(n)) begin
                case (address[1:0])
                    c_REG_STATUS:  readdata_d = {30'd0, run_q[n], to_q[n]};
                    c_REG_CONTROL: readdata_d = {16'd0, presc_q[n], 6'd0, cont_q[n], ito_q[n]};
                    c_REG_PERIOD:  readdata_d = 32'(period_q[n]);
                    default:       readdata_d = 32'(snap_q[n]);
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= {NUM_CH{c_RESET_CNT}};
            period_q   <= {NUM_CH{c_RESET_CNT}};
            snap_q     <= '0;
            presc_q    <= '0;
            pcnt_q     <= '0;
            to_q       <= '0;
            run_q      <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            readdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            to_q       <= to_d;
            run_q      <= run_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            readdata_q <= readdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_de0_nano_system_multitimer.sv
`default_nettype none
// ============================================================================
// Module   : tb_de0_nano_system_multitimer
// Brief    : Self-checking bench: register table, directed timing sequences
//            and randomized bus traffic against a behavioural timer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de0_nano_system_multitimer;

    localparam int NCH   = 2;
    localparam int RST_P = 9999;

    logic           clk        = 1'b0;
    logic           reset_n    = 1'b0;
    logic           chipselect = 1'b0;
    logic           write_n    = 1'b1;
    logic [3:0]     address    = 4'h0;
    logic [31:0]    writedata  = 32'h0;
    logic [31:0]    readdata;
    logic           irq;
    logic [NCH-1:0] irq_vec;

    int checks = 0;
    int errors = 0;

    de0_nano_system_multitimer #(
        .NUM_CH       (NCH),
        .CNT_W        (32),
        .RESET_PERIOD (RST_P)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    // Behavioural channel: timeouts happen when the tick number since the
    // last prescaler restart is a multiple of PRESCALE+1 and the count is 0.
    typedef struct {
        int unsigned cnt;
        int unsigned period;
        int unsigned snap;
        int unsigned presc;
        int unsigned elapsed;
        bit          to;
        bit          run;
        bit          ito;
        bit          cont;
    } ch_t;

    ch_t         m [4];
    logic [31:0] m_rd;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        int c;
        c = int'(a[3:2]);
        if (c >= NCH) return 32'h0;
        case (a[1:0])
            2'd0:    return {30'd0, m[c].run, m[c].to};
            2'd1:    return {16'd0, 8'(m[c].presc), 6'd0, m[c].cont, m[c].ito};
            2'd2:    return m[c].period;
            default: return m[c].snap;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic cs, input logic wn,
                              input logic [3:0] a, input logic [31:0] wd);
        ch_t n;
        bit  tick;
        bit  tmo;
        if (rst) begin
            m_rd = 32'h0;
            for (int i = 0; i < 4; i++) begin
                m[i].cnt = RST_P; m[i].period = RST_P; m[i].snap = 0;
                m[i].presc = 0; m[i].elapsed = 0;
                m[i].to = 0; m[i].run = 0; m[i].ito = 0; m[i].cont = 0;
            end
            return;
        end
        m_rd = mread(a);
        for (int i = 0; i < NCH; i++) begin
            n    = m[i];
            tick = m[i].run && ((m[i].elapsed % (m[i].presc + 1)) == m[i].presc);
            tmo  = tick && (m[i].cnt == 0);
            n.elapsed = m[i].run ? m[i].elapsed + 1 : 0;
            if (tick) n.cnt = tmo ? m[i].period : m[i].cnt - 1;
            if (tmo) begin
                n.to = 1;
                if (!m[i].cont) n.run = 0;
            end
            if (cs && !wn && int'(a[3:2]) == i) begin
                case (a[1:0])
                    2'd0: n.to = tmo;
                    2'd1: begin
                        n.ito = wd[0]; n.cont = wd[1]; n.presc = wd[15:8];
                        if (wd[2]) begin n.run = 1; n.elapsed = 0; end
                        else if (wd[3]) begin n.run = 0; n.elapsed = 0; end
                    end
                    2'd2: begin n.period = wd; n.cnt = wd; n.run = 0; n.elapsed = 0; end
                    default: n.snap = m[i].cnt;
                endcase
            end
            if (!n.run) n.elapsed = 0;
            m[i] = n;
        end
    endtask

    // One bus cycle; interrupt outputs are compared against the model every cycle.
    task automatic cyc(input logic cs, input logic wn, input logic [3:0] a,
                       input logic [31:0] wd, input logic rst);
        logic [NCH-1:0] ev;
        chipselect = cs; write_n = wn; address = a; writedata = wd; reset_n = !rst;
        @(posedge clk);
        model_step(rst, cs, wn, a, wd);
        #1;
        for (int i = 0; i < NCH; i++) ev[i] = m[i].to && m[i].ito;
        chk("irq_vec_model", 32'(irq_vec), 32'(ev));
        chk("irq_model", 32'(irq), 32'(|ev));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d); cyc(1'b1, 1'b0, a, d, 1'b0); endtask
    task automatic rd(input logic [3:0] a); cyc(1'b1, 1'b1, a, 32'h0, 1'b0); endtask
    task automatic idle(); cyc(1'b0, 1'b1, 4'h0, 32'h0, 1'b0); endtask
    task automatic do_reset(); cyc(1'b0, 1'b1, 4'h0, 32'h0, 1'b1); endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rw;

        // Register map walk after reset; exp is readdata after that cycle.
        tbl[0]  = '{1'b0, 1'b1, 4'h0, 32'h0,   32'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'h1, 32'h0,   32'h0};
        tbl[2]  = '{1'b0, 1'b1, 4'h2, 32'h0,   32'd9999};
        tbl[3]  = '{1'b0, 1'b1, 4'h3, 32'h0,   32'h0};
        tbl[4]  = '{1'b1, 1'b1, 4'h6, 32'h0,   32'd9999};
        tbl[5]  = '{1'b1, 1'b0, 4'h1, 32'hC,   32'h0};
        tbl[6]  = '{1'b1, 1'b1, 4'h0, 32'h0,   32'h2};
        tbl[7]  = '{1'b1, 1'b1, 4'h1, 32'h0,   32'h0};
        tbl[8]  = '{1'b1, 1'b1, 4'hC, 32'h0,   32'h0};
        tbl[9]  = '{1'b1, 1'b0, 4'hE, 32'h5,   32'h0};
        tbl[10] = '{1'b1, 1'b1, 4'hE, 32'h0,   32'h0};
        tbl[11] = '{1'b1, 1'b0, 4'h2, 32'd100, 32'd9999};
        tbl[12] = '{1'b1, 1'b1, 4'h0, 32'h0,   32'h0};
        tbl[13] = '{1'b1, 1'b0, 4'h3, 32'h0,   32'h0};
        tbl[14] = '{1'b1, 1'b1, 4'h3, 32'h0,   32'd100};
        tbl[15] = '{1'b1, 1'b1, 4'h6, 32'h0,   32'd9999};
        tbl[16] = '{1'b1, 1'b1, 4'h5, 32'h0,   32'h0};
        tbl[17] = '{1'b1, 1'b1, 4'h4, 32'h0,   32'h0};

        do_reset();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, 1'b0);
            chk($sformatf("table_%0d", i), readdata, tbl[i].exp);
        end

        // Continuous ch0, period 4: timeout 5 clocks after START, then every 5.
        do_reset();
        wr(4'h2, 32'd4);
        wr(4'h1, 32'h7);
        for (int k = 1; k <= 5; k++) begin
            idle();
            chk($sformatf("cont_first_k%0d", k), 32'(irq_vec[0]), 32'(k == 5));
        end
        rd(4'h0);
        chk("cont_status_run", readdata, 32'h3);
        wr(4'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            idle();
            chk($sformatf("cont_repeat_k%0d", k), 32'(irq_vec[0]), 32'(k == 3));
        end

        // One-shot ch1, period 2, prescale 3: single timeout after 12 clocks.
        do_reset();
        wr(4'h6, 32'd2);
        wr(4'h5, 32'h305);
        for (int k = 1; k <= 12; k++) begin
            idle();
            chk($sformatf("oneshot_k%0d", k), 32'(irq_vec[1]), 32'(k == 12));
        end
        for (int k = 0; k < 6; k++) idle();
        rd(4'h4);
        chk("oneshot_status", readdata, 32'h1);
        wr(4'h7, 32'h0);
        rd(4'h7);
        chk("oneshot_snap", readdata, 32'd2);

        // STATUS write on the timeout cycle keeps TO; one cycle later clears it.
        do_reset();
        wr(4'h2, 32'd4);
        wr(4'h1, 32'h7);
        for (int k = 0; k < 4; k++) idle();
        wr(4'h0, 32'h0);
        chk("clr_on_timeout_keeps", 32'(irq_vec[0]), 32'h1);
        wr(4'h0, 32'h0);
        chk("clr_after_timeout", 32'(irq), 32'h0);
        rd(4'h0);
        chk("clr_status", readdata, 32'h2);

        // Reset mid-count abandons everything.
        do_reset();
        wr(4'h2, 32'd4);
        wr(4'h1, 32'h7);
        for (int k = 0; k < 3; k++) idle();
        do_reset();
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_irq", 32'(irq), 32'h0);
        rd(4'h0); chk("midreset_status", readdata, 32'h0);
        rd(4'h1); chk("midreset_control", readdata, 32'h0);
        rd(4'h2); chk("midreset_period", readdata, 32'd9999);
        rd(4'h3); chk("midreset_snap", readdata, 32'h0);
        for (int k = 0; k < 10; k++) idle();

        // Randomized traffic; CONTROL writes always carry START or STOP.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 3) begin
                case (ra[1:0])
                    2'd1: rw = {16'h0, 8'($urandom_range(0, 3)), 4'h0,
                                2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
                    2'd2: rw = 32'($urandom_range(0, 7));
                    default: rw = $urandom;
                endcase
                wr(ra, rw);
            end else begin
                cyc(1'($urandom_range(0, 1)), 1'b1, ra, $urandom, 1'b0);
            end
            chk("rand_readdata", readdata, m_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
